// File: rtl/hazard_ctrl_unit.sv
// Decode-side hazard controller: tracks in-flight writers in a small scoreboard and
// derives stall / bubble / flush / freeze controls, plus saturating stall counters.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int BR_DEPTH   = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [3:0]        dec_opcode,
  input  logic [REG_AW-1:0] srcReg1,
  input  logic [REG_AW-1:0] srcReg2,
  input  logic [REG_AW-1:0] dec_dstReg,
  input  logic              dec_regWrite,
  input  logic              dec_memRead,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_ifid,
  output logic              freeze,
  output logic [CNT_W-1:0]  hz_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  localparam logic [3:0] OP_BR = 4'hD;
  localparam logic [PIPE_DEPTH-1:0] BR_MASK = PIPE_DEPTH'((1 << BR_DEPTH) - 1);

  typedef struct packed {
    logic              v;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] dst;
  } sb_ent_t;

  sb_ent_t [PIPE_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]         hz_cnt_q, hz_cnt_d, mem_cnt_q, mem_cnt_d;

  logic [PIPE_DEPTH-1:0] wr_s1, wr_s2;
  logic                  src2_used, load_use, br_haz, hazard;

  // R0 is hardwired zero, so it never matches as a live writer
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
    assign wr_s1[k] = sb_q[k].v & sb_q[k].wr & (sb_q[k].dst == srcReg1) & (srcReg1 != '0);
    assign wr_s2[k] = sb_q[k].v & sb_q[k].wr & (sb_q[k].dst == srcReg2) & (srcReg2 != '0);
  end

  always_comb begin
    src2_used = ~((dec_opcode == 4'h4) | (dec_opcode == 4'h5) |
                  (dec_opcode == 4'h6) | dec_opcode[3]);
    load_use  = sb_q[0].ld & (wr_s1[0] | (src2_used & wr_s2[0]));
    br_haz    = (dec_opcode == OP_BR) & (|(wr_s1 & BR_MASK));
    hazard    = dec_valid & (load_use | br_haz);
  end

  always_comb begin
    freeze     = rst_n & mem_busy;
    stall_if   = rst_n & (freeze | hazard);
    bubble_ex  = rst_n & hazard & ~freeze;
    flush_ifid = rst_n & br_taken & dec_valid & ~stall_if;
  end

  always_comb begin
    sb_d      = sb_q;
    hz_cnt_d  = hz_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (!freeze) begin
      for (int k = 1; k < PIPE_DEPTH; k++) sb_d[k] = sb_q[k-1];
      if (hazard || !dec_valid) sb_d[0] = '0;
      else sb_d[0] = '{v: 1'b1, wr: dec_regWrite, ld: dec_memRead, dst: dec_dstReg};
    end
    if (bubble_ex && hz_cnt_q != '1) hz_cnt_d = hz_cnt_q + 1'b1;
    if (freeze && mem_cnt_q != '1)   mem_cnt_d = mem_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q      <= '0;
      hz_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      sb_q      <= sb_d;
      hz_cnt_q  <= hz_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign hz_stall_cnt  = hz_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench: each cycle's expected controls/counters are queued with the
// stimulus and compared half a cycle later; a CNT_W=3 copy checks counter saturation.
module tb_hazard_ctrl_unit;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SLL = 4'h4, OP_LW = 4'h9, OP_BR = 4'hD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, dec_valid, dec_regWrite, dec_memRead, br_taken, mem_busy;
  logic [3:0] dec_opcode, srcReg1, srcReg2, dec_dstReg;
  logic       stall_if, bubble_ex, flush_ifid, freeze;
  logic [15:0] hz_cnt, mem_cnt;
  logic       s3_stall, s3_bub, s3_flush, s3_frz;
  logic [2:0] hz_cnt3, mem_cnt3;

  hazard_ctrl_unit u_dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .srcReg1(srcReg1), .srcReg2(srcReg2), .dec_dstReg(dec_dstReg),
    .dec_regWrite(dec_regWrite), .dec_memRead(dec_memRead), .br_taken(br_taken),
    .mem_busy(mem_busy), .stall_if(stall_if), .bubble_ex(bubble_ex),
    .flush_ifid(flush_ifid), .freeze(freeze), .hz_stall_cnt(hz_cnt), .mem_stall_cnt(mem_cnt)
  );

  hazard_ctrl_unit #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .srcReg1(srcReg1), .srcReg2(srcReg2), .dec_dstReg(dec_dstReg),
    .dec_regWrite(dec_regWrite), .dec_memRead(dec_memRead), .br_taken(br_taken),
    .mem_busy(mem_busy), .stall_if(s3_stall), .bubble_ex(s3_bub),
    .flush_ifid(s3_flush), .freeze(s3_frz), .hz_stall_cnt(hz_cnt3), .mem_stall_cnt(mem_cnt3)
  );

  typedef struct {
    logic stall, bub, flush, frz;
    int   hz, mem, hz3, mem3;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   e_hz = 0, e_mem = 0, e_hz3 = 0, e_mem3 = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // one cycle: drive ID inputs, queue expectations, sample at negedge
  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] dst,
                      input logic rw, input logic mr, input logic bt, input logic mb,
                      input logic x_stall, input logic x_bub, input logic x_flush,
                      input logic x_frz);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rst; dec_valid = v; dec_opcode = op; srcReg1 = s1; srcReg2 = s2;
    dec_dstReg = dst; dec_regWrite = rw; dec_memRead = mr; br_taken = bt; mem_busy = mb;
    e = '{x_stall, x_bub, x_flush, x_frz, e_hz, e_mem, e_hz3, e_mem3};
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("stall_if",   int'(stall_if),   int'(e.stall));
      chk("bubble_ex",  int'(bubble_ex),  int'(e.bub));
      chk("flush_ifid", int'(flush_ifid), int'(e.flush));
      chk("freeze",     int'(freeze),     int'(e.frz));
      chk("hz_cnt",     int'(hz_cnt),     e.hz);
      chk("mem_cnt",    int'(mem_cnt),    e.mem);
      chk("hz_cnt3",    int'(hz_cnt3),    e.hz3);
      chk("mem_cnt3",   int'(mem_cnt3),   e.mem3);
    end
    // counters seen next cycle
    if (!rst) begin
      e_hz = 0; e_mem = 0; e_hz3 = 0; e_mem3 = 0;
    end else begin
      if (x_bub) begin e_hz++; if (e_hz3 < 7) e_hz3++; end
      if (x_frz) begin e_mem++; if (e_mem3 < 7) e_mem3++; end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; dec_valid = 0; dec_opcode = 0; srcReg1 = 0; srcReg2 = 0;
    dec_dstReg = 0; dec_regWrite = 0; dec_memRead = 0; br_taken = 0; mem_busy = 0;
    repeat (2) @(posedge clk);
    // outputs forced low while in reset, even with hazard-ish inputs
    step(0, 1, OP_BR, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);

    // load-use: LW R3 ; ADD R4,R3,R5 stalls one cycle then issues
    step(1, 1, OP_LW,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(3);

    // SLL reads no src2: no stall
    step(1, 1, OP_LW,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, OP_SLL, 2, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(3);

    // ADD R7 then BR R7: two stall cycles, third cycle clear
    step(1, 1, OP_ADD, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, OP_BR,  7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, OP_BR,  7, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, OP_BR,  7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(3);

    // LW R7 then BR R7 with br_taken: flush suppressed while stalled, then flush
    step(1, 1, OP_LW,  0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, OP_BR,  7, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    step(1, 1, OP_BR,  7, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    step(1, 1, OP_BR,  7, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    nop(3);

    // write to R0 never creates a hazard; taken branch flushes
    step(1, 1, OP_ADD, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, OP_BR,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    nop(3);

    // mem_busy 4 cycles over a load-use: freeze holds, one bubble after release
    step(1, 1, OP_LW,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 1, 1, 0, 0, 1);
    step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(3);

    // reset mid-stall drops tracking and counters
    step(1, 1, OP_LW,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(3);

    // 10 load-use bubbles: 3-bit counter pins at 7
    for (int i = 0; i < 10; i++) begin
      step(1, 1, OP_LW,  0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 1, 1, 0, 0);
      step(1, 1, OP_ADD, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    // 9 freeze cycles: 3-bit mem counter pins at 7
    for (int i = 0; i < 9; i++) step(1, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    nop(2);
    chk("hz_sat_final",  int'(hz_cnt3),  7);
    chk("mem_sat_final", int'(mem_cnt3), 7);
    chk("hz_full_final", int'(hz_cnt),   10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
